// File: rtl/fwd_sel_ctrl.sv
// rtl/fwd_sel_ctrl.sv - operand forwarding select and load-use stall generation
// Shadows destination tags of EX/MEM/WB to steer the two ALU operand muxes.
module fwd_sel_ctrl #(
   parameter int RA_W           = 5,
   parameter bit ZERO_HARDWIRED = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_valid,
   input  logic [RA_W-1:0] issue_rd,
   input  logic            issue_we,
   input  logic            issue_load,
   input  logic [RA_W-1:0] rs_a,
   input  logic [RA_W-1:0] rs_b,
   input  logic            rs_a_used,
   input  logic            rs_b_used,
   input  logic            flush,
   output logic [1:0]      sel_a,
   output logic [1:0]      sel_b,
   output logic            stall
);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_EX  = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;
   localparam logic [1:0] SEL_WB  = 2'b11;

   logic            ex_valid_q,  ex_valid_d;
   logic [RA_W-1:0] ex_rd_q,     ex_rd_d;
   logic            ex_we_q,     ex_we_d;
   logic            ex_load_q,   ex_load_d;
   logic            mem_valid_q, mem_valid_d;
   logic [RA_W-1:0] mem_rd_q,    mem_rd_d;
   logic            mem_we_q,    mem_we_d;
   logic            mem_load_q,  mem_load_d;
   logic            wb_valid_q,  wb_valid_d;
   logic [RA_W-1:0] wb_rd_q,     wb_rd_d;
   logic            wb_we_q,     wb_we_d;
   logic            wb_load_q,   wb_load_d;

   logic            src_a_live, src_b_live;
   logic            ex_hit_a,  mem_hit_a, wb_hit_a;
   logic            ex_hit_b,  mem_hit_b, wb_hit_b;
   logic            lu_a, lu_b;

   // Register 0 is never a forwarding source when it is hardwired to zero.
   always_comb begin
      src_a_live = rs_a_used & ~(ZERO_HARDWIRED & (rs_a == '0));
      src_b_live = rs_b_used & ~(ZERO_HARDWIRED & (rs_b == '0));
   end

   always_comb begin
      ex_hit_a  = src_a_live & ex_valid_q  & ex_we_q  & (ex_rd_q  == rs_a);
      mem_hit_a = src_a_live & mem_valid_q & mem_we_q & (mem_rd_q == rs_a);
      wb_hit_a  = src_a_live & wb_valid_q  & wb_we_q  & (wb_rd_q  == rs_a);
      ex_hit_b  = src_b_live & ex_valid_q  & ex_we_q  & (ex_rd_q  == rs_b);
      mem_hit_b = src_b_live & mem_valid_q & mem_we_q & (mem_rd_q == rs_b);
      wb_hit_b  = src_b_live & wb_valid_q  & wb_we_q  & (wb_rd_q  == rs_b);
   end

   always_comb begin
      lu_a  = ex_hit_a & ex_load_q;
      lu_b  = ex_hit_b & ex_load_q;
      stall = (lu_a | lu_b) & ~flush;
   end

   // A load in EX shadows older producers but has no data yet, so in0 is
   // reported until it reaches MEM.
   always_comb begin
      sel_a = SEL_RF;
      if (ex_hit_a) begin
         sel_a = ex_load_q ? SEL_RF : SEL_EX;
      end else if (mem_hit_a) begin
         sel_a = SEL_MEM;
      end else if (wb_hit_a) begin
         sel_a = SEL_WB;
      end
   end

   always_comb begin
      sel_b = SEL_RF;
      if (ex_hit_b) begin
         sel_b = ex_load_q ? SEL_RF : SEL_EX;
      end else if (mem_hit_b) begin
         sel_b = SEL_MEM;
      end else if (wb_hit_b) begin
         sel_b = SEL_WB;
      end
   end

   always_comb begin
      wb_valid_d  = mem_valid_q;
      wb_rd_d     = mem_rd_q;
      wb_we_d     = mem_we_q;
      wb_load_d   = mem_load_q;

      mem_valid_d = ex_valid_q & ~flush;
      mem_rd_d    = ex_rd_q;
      mem_we_d    = ex_we_q;
      mem_load_d  = ex_load_q;

      ex_valid_d  = issue_valid & ~stall & ~flush;
      ex_rd_d     = issue_rd;
      ex_we_d     = issue_we;
      ex_load_d   = issue_load;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid_q  <= 1'b0;
         ex_rd_q     <= '0;
         ex_we_q     <= 1'b0;
         ex_load_q   <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_rd_q    <= '0;
         mem_we_q    <= 1'b0;
         mem_load_q  <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_we_q     <= 1'b0;
         wb_load_q   <= 1'b0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_rd_q     <= ex_rd_d;
         ex_we_q     <= ex_we_d;
         ex_load_q   <= ex_load_d;
         mem_valid_q <= mem_valid_d;
         mem_rd_q    <= mem_rd_d;
         mem_we_q    <= mem_we_d;
         mem_load_q  <= mem_load_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_we_q     <= wb_we_d;
         wb_load_q   <= wb_load_d;
      end
   end

   // The load flag leaves the shadow pipe at WB; it only matters in EX.
   logic unused_ok;
   assign unused_ok = wb_load_q;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// tb/tb_fwd_sel_ctrl.sv - randomized and directed check of fwd_sel_ctrl against a tag-queue model
module tb_fwd_sel_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       issue_valid;
   logic [4:0] issue_rd;
   logic       issue_we;
   logic       issue_load;
   logic [4:0] rs_a, rs_b;
   logic       rs_a_used, rs_b_used;
   logic       flush;
   logic [1:0] sel_a, sel_b;
   logic       stall;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   fwd_sel_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_we    (issue_we),
      .issue_load  (issue_load),
      .rs_a        (rs_a),
      .rs_b        (rs_b),
      .rs_a_used   (rs_a_used),
      .rs_b_used   (rs_b_used),
      .flush       (flush),
      .sel_a       (sel_a),
      .sel_b       (sel_b),
      .stall       (stall)
   );

   typedef struct packed {
      bit       v;
      bit [4:0] rd;
      bit       we;
      bit       ld;
   } ent_t;

   // Index 0 is the youngest in-flight instruction (EX), 2 the oldest (WB).
   ent_t pipe [3];

   function automatic bit produces(ent_t e, bit [4:0] s, bit u);
      return e.v && e.we && (e.rd == s) && u && (s != 5'd0);
   endfunction

   // Returns {waits_on_load, mux_input}; mux input is 1 + age of producer.
   function automatic bit [2:0] resolve(bit [4:0] s, bit u);
      for (int k = 0; k < 3; k++) begin
         if (produces(pipe[k], s, u)) begin
            if (k == 0 && pipe[0].ld) return 3'b100;
            return {1'b0, 2'(k + 1)};
         end
      end
      return 3'b000;
   endfunction

   task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic cycle(input bit iv, input bit [4:0] ird, input bit iwe, input bit ild,
                        input bit [4:0] ra, input bit ua, input bit [4:0] rb, input bit ub,
                        input bit fl, input bit rst, input bit armed,
                        input bit lit, input bit [1:0] ea, input bit [1:0] eb, input bit es);
      bit [2:0] ra_r, rb_r;
      bit       m_stall;
      ent_t     nxt;
      issue_valid = iv; issue_rd = ird; issue_we = iwe; issue_load = ild;
      rs_a = ra; rs_a_used = ua; rs_b = rb; rs_b_used = ub;
      flush = fl; reset = rst;
      @(negedge clk);
      ra_r    = resolve(ra, ua);
      rb_r    = resolve(rb, ub);
      m_stall = (ra_r[2] | rb_r[2]) & ~fl;
      if (armed) begin
         chk("sel_a", sel_a, ra_r[1:0]);
         chk("sel_b", sel_b, rb_r[1:0]);
         chk("stall", {1'b0, stall}, {1'b0, m_stall});
         if (lit) begin
            chk("lit_model_sel_a", ra_r[1:0], ea);
            chk("lit_sel_a", sel_a, ea);
            chk("lit_sel_b", sel_b, eb);
            chk("lit_stall", {1'b0, stall}, {1'b0, es});
         end
      end
      @(posedge clk);
      if (rst) begin
         for (int k = 0; k < 3; k++) pipe[k] = '0;
      end else begin
         nxt     = '{v: iv & ~m_stall & ~fl, rd: ird, we: iwe, ld: ild};
         pipe[2] = pipe[1];
         pipe[1] = fl ? ent_t'('0) : pipe[0];
         pipe[0] = nxt;
      end
      #1;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) pipe[k] = '0;
      //     iv ird we ld  ra ua rb ub fl rst arm lit ea eb es
      cycle(0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0,  3, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      cycle(1, 5, 1, 0,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      cycle(0, 0, 0, 0,  5, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      cycle(0, 0, 0, 0,  5, 1, 0, 0, 0, 0, 1, 1, 2, 0, 0);
      cycle(0, 0, 0, 0,  5, 1, 0, 0, 0, 0, 1, 1, 3, 0, 0);
      cycle(0, 0, 0, 0,  5, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      cycle(1, 7, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      cycle(1, 7, 1, 0,  7, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      cycle(0, 0, 0, 0,  7, 1, 7, 1, 0, 0, 1, 1, 1, 1, 0);
      cycle(1, 4, 1, 1,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      cycle(1, 9, 1, 0,  0, 0, 4, 1, 0, 0, 1, 1, 0, 0, 1);
      cycle(1, 9, 1, 0,  0, 0, 4, 1, 0, 0, 1, 1, 0, 2, 0);
      cycle(1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0,  0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
      cycle(1, 4, 1, 1,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0,  4, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      cycle(1, 4, 1, 1,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      cycle(1, 8, 1, 0,  4, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0);
      cycle(0, 0, 0, 0,  4, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      cycle(1, 6, 1, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      cycle(1, 6, 1, 0,  6, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0);
      cycle(0, 0, 0, 0,  6, 1, 6, 1, 0, 0, 1, 1, 0, 0, 0);

      for (int n = 0; n < 4000; n++) begin
         cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
               $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
               5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
               5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
               1, 0, 0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fwd_sel_ctrl.md
Name: fwd_sel_ctrl

Overview:
- Generates the 2-bit select codes for the two 32-bit 4:1 operand muxes in front of the ALU.
- Mux input assignment: in0 = register-file read data, in1 = EX result, in2 = MEM result, in3 = WB result.
- Tracks destination tags of in-flight instructions in a 3-stage shadow pipeline (EX, MEM, WB), so sel always points at the youngest valid producer.
- Raises a load-use stall when the operand cannot be forwarded yet.

Parameters:
- RA_W, 5, register address width (32 architectural registers).
- ZERO_HARDWIRED, 1, when 1 register 0 never matches and always selects in0.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; clears all pipeline tag state.
- issue_valid  input  1  instruction in decode is valid and advances to EX this cycle unless stalled.
- issue_rd  input  RA_W  destination register of decoding instruction.
- issue_we  input  1  decoding instruction writes issue_rd.
- issue_load  input  1  decoding instruction is a load; result is available only from MEM onward.
- rs_a  input  RA_W  source register for operand A.
- rs_b  input  RA_W  source register for operand B.
- rs_a_used  input  1  operand A is actually read.
- rs_b_used  input  1  operand B is actually read.
- flush  input  1  kill decoding instruction and the EX entry (branch redirect).
- sel_a  output  2  mux select for operand A.
- sel_b  output  2  mux select for operand B.
- stall  output  1  hold decode/fetch; a bubble is inserted into EX.

Behaviour:
- State: three tag entries, EX, MEM and WB. Each entry holds {valid, rd, we, load}.
- reset=1: all entry valids go to 0 at the clock edge. With all valids 0, the outputs are sel_a=sel_b=2'b00 and stall=0 from the first cycle after reset.
- reset has priority over flush and issue. Reset mid-stream discards all entries; no forwarding from pre-reset instructions.
- Advance every cycle (the pipeline never freezes below decode):
  - WB <= MEM.
  - MEM <= EX, or an invalid entry if flush=1.
  - EX <= issue entry, valid = issue_valid & ~stall & ~flush.
- Stall: EX is loaded with a bubble (valid=0), and decode re-presents the same instruction next cycle.
- An entry "matches" source s when valid & we & (rd == s) & s_used & ~(ZERO_HARDWIRED & s == 0).
- sel per operand is combinational from current state and current rs inputs, with fixed priority youngest-first:
  - EX match and EX.load=0 -> 2'b01.
  - else MEM match -> 2'b10.
  - else WB match -> 2'b11.
  - else 2'b00.
- A match in an older stage is ignored whenever a younger stage also matches, even if the younger stage is a load.
- Load-use: stall = (EX match on A with EX.load=1) | (EX match on B with EX.load=1).
  - While stall=1, the affected sel is 2'b00. The unaffected operand still reports its normal sel.
  - Next cycle the load is in MEM, the bubble is in EX, stall drops, and sel = 2'b10.
- Stall is suppressed when flush=1 (the instruction is being killed anyway).
- A WB match coexists with register-file write in the same cycle. in3 is selected, so no write-before-read requirement is placed on the register file.
- issue_we=0 entries never match regardless of rd.
- Both operands may name the same register; each sel is derived independently and gives identical results.

Test Plan:
- Reset, then rs_a=3 used with no prior issue -> sel_a=00, sel_b=00, stall=0.
- Issue ALU write r5, next cycle rs_a=5 -> sel_a=01. Following cycles with no new writer to r5 -> 10, then 11, then 00.
- Issue write r7 twice back-to-back, then read r7 -> sel=01, not 10 (youngest wins).
- Load to r4, next cycle rs_b=4 used -> stall=1, sel_b=00, EX bubble. Following cycle -> stall=0, sel_b=10.
- Issue write r0, then read r0 -> sel=00 (ZERO_HARDWIRED=1). Repeat with rs_a_used=0 on a matching reg -> sel_a=00, no stall.
- Load r4 in EX with flush=1 and rs_a=4 -> stall=0. Next cycle MEM entry invalid -> sel_a=00. Then assert reset with valid entries -> all sel=00 on the following cycle.
